// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//
// Accepts parallel words over a valid/ready handshake and scans them MSB first
// through an overlapping PAT_W-bit sequence matcher. Consecutive words form one
// continuous bit stream, so a match may straddle a word boundary. Each word
// produces one result: the number of matches that ended inside it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. The producer holds data stable while valid is high and not yet
// accepted. m_valid/m_hits stay unchanged until m_ready is seen.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   cfg_we, cfg_pat  pattern load (IDLE only); also clears history and fill
//   flush            clears history and fill (IDLE only)
//   s_valid/s_ready/s_data   input word stream
//   m_valid/m_ready/m_hits   per-word result
//   total_hits       saturating count of all matches since reset
//   busy             high in SHIFT or REPORT
//   dbg_state        current FSM state (0 IDLE, 1 SHIFT, 2 REPORT)

module pattern_scan_ctrl #(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 16,
    parameter int               HIT_W   = $clog2(WORD_W + 1),
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [HIT_W-1:0]  m_hits,
    output logic [CNT_W-1:0]  total_hits,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    // Only the last PAT_W-1 bits are kept; the incoming bit completes the window.
    logic [PAT_W-2:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [CNT_W-1:0]    total_q, total_d;

    logic                cur_bit;
    logic [PAT_W-1:0]    window;
    logic                is_match;

    assign cur_bit  = word_q[idx_q];
    assign window   = {hist_q, cur_bit};
    // fill counts bits seen before this one, so PAT_W-1 means a full window now.
    assign is_match = (window == pat_q) && (fill_q >= FILL_NEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            hits_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            hits_q  <= hits_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        word_d  = word_q;
        idx_d   = idx_q;
        hits_d  = hits_q;
        total_d = total_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d  = cfg_pat;
                    hist_d = '0;
                    fill_d = '0;
                end else if (flush) begin
                    hist_d = '0;
                    fill_d = '0;
                end else if (s_valid) begin
                    word_d  = s_data;
                    idx_d   = IDX_TOP;
                    hits_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hist_d = window[PAT_W-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if (is_match) begin
                    hits_d = hits_q + HIT_W'(1);
                    if (total_q != {CNT_W{1'b1}}) begin
                        total_d = total_q + CNT_W'(1);
                    end
                end
                if (idx_q == '0) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            REPORT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready    = (state_q == IDLE) && !cfg_we && !flush;
    assign m_valid    = (state_q == REPORT);
    assign busy       = (state_q != IDLE);
    assign m_hits     = hits_q;
    assign total_hits = total_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl. Two instances share every input: the
// main one with default parameters and a second with a 4-bit total counter,
// which only differs in how total_hits saturates.

module tb_pattern_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_pat;
    logic        flush;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        m_ready;

    logic        s_ready, m_valid, busy;
    logic [3:0]  m_hits;
    logic [15:0] total_hits;
    logic [1:0]  dbg_state;

    logic        sat_s_ready, sat_m_valid, sat_busy;
    logic [3:0]  sat_m_hits;
    logic [3:0]  sat_total;
    logic [1:0]  sat_dbg_state;

    int n_checks;
    int n_pass;

    logic [3:0] exp_q[$];

    pattern_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_pat    (cfg_pat),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_hits     (m_hits),
        .total_hits (total_hits),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    pattern_scan_ctrl #(.CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_pat    (cfg_pat),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (sat_s_ready),
        .s_data     (s_data),
        .m_valid    (sat_m_valid),
        .m_ready    (m_ready),
        .m_hits     (sat_m_hits),
        .total_hits (sat_total),
        .busy       (sat_busy),
        .dbg_state  (sat_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cfg_we  = 1'b0;
        cfg_pat = 4'b0000;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_cfg(input logic [3:0] pat);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_pat = pat;
        #1 check("cfg_s_ready", s_ready, 1'b0);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_s_ready", s_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Sends one word, waits for its result, optionally holds m_ready low for
    // hold_cyc cycles first, then completes the handshake.
    task automatic send_word(input logic [7:0] data, input logic [3:0] exp_hits,
                             input logic [15:0] exp_total, input logic [3:0] exp_sat,
                             input int hold_cyc);
        int n;
        logic [3:0] hits_seen;
        logic [3:0] exp_h;
        exp_q.push_back(exp_hits);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = data;
        #1 check("idle_s_ready", s_ready, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 8);
        exp_h = exp_q.pop_front();
        check("m_hits", m_hits, exp_h);
        check("total_hits", total_hits, exp_total);
        check("sat_total", sat_total, exp_sat);
        hits_seen = m_hits;
        s_valid = 1'b1;
        for (int i = 0; i < hold_cyc; i++) begin
            @(negedge clk);
            check("hold_m_valid", m_valid, 1'b1);
            check("hold_m_hits", m_hits, hits_seen);
            check("hold_s_ready", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("m_valid_drop", m_valid, 1'b0);
        check("busy_drop", busy, 1'b0);
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        do_reset();

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_hits", m_hits, 4'd0);
        check("rst_total", total_hits, 16'd0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_s_ready", s_ready, 1'b1);

        // Default pattern 1011 on 1011_0110: hits at bits 4 and 7
        send_word(8'b1011_0110, 4'd2, 16'd2, 4'd2, 0);

        // Cross-word match: ..0101 | 1... completes 1011
        send_word(8'b0000_0101, 4'd0, 16'd2, 4'd2, 0);
        send_word(8'b1000_0000, 4'd1, 16'd3, 4'd3, 0);
        // Same pair with flush between: history gone, no match
        send_word(8'b0000_0101, 4'd0, 16'd3, 4'd3, 0);
        pulse_flush();
        send_word(8'b1000_0000, 4'd0, 16'd3, 4'd3, 0);

        // Reconfigure to 1111: FF gives overlapping hits at bits 4..8
        pulse_cfg(4'b1111);
        send_word(8'hFF, 4'd5, 16'd8, 4'd8, 0);

        // cfg_we wins over s_valid: word must not be accepted
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_pat = 4'b1111;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        #1 check("cfg_vs_valid_s_ready", s_ready, 1'b0);
        @(negedge clk);
        cfg_we  = 1'b0;
        s_valid = 1'b0;
        check("cfg_vs_valid_busy", busy, 1'b0);
        @(negedge clk);
        check("cfg_vs_valid_busy2", busy, 1'b0);

        // Backpressure: F0 after config clear gives 1 hit; hold 5 cycles
        send_word(8'hF0, 4'd1, 16'd9, 4'd9, 5);
        @(negedge clk);
        check("after_bp_busy", busy, 1'b0);

        // Saturation: fresh reset, 1111, three FF words (5+8+8)
        do_reset();
        pulse_cfg(4'b1111);
        send_word(8'hFF, 4'd5, 16'd5, 4'd5, 0);
        send_word(8'hFF, 4'd8, 16'd13, 4'd13, 0);
        send_word(8'hFF, 4'd8, 16'd21, 4'd15, 0);

        // Reset three cycles into SHIFT
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_total", total_hits, 16'd0);
        check("midrst_sat_total", sat_total, 4'd0);
        check("midrst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_result", m_valid, 1'b0);
        // Pattern must be back to 1011
        send_word(8'b1011_0110, 4'd2, 16'd2, 4'd2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule
